// File: rtl/pll_supervisor_if.sv
// Signal bundle between the PLL supervisor and the PLL/system side.
// master = supervisor, slave = PLL macro / reset consumers.
interface pll_supervisor_if;
  logic       extlock;
  logic       force_relock;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       locked;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lol_cnt;

  modport master (
    input  extlock, force_relock,
    output pll_reset, sys_rst_n, locked, fault, retry_cnt, lol_cnt
  );

  modport slave (
    output extlock, force_relock,
    input  pll_reset, sys_rst_n, locked, fault, retry_cnt, lol_cnt
  );
endinterface

// File: rtl/pll_supervisor.sv
// PLL reset/lock supervisor in the refclk domain: pulses the PLL reset, waits for a
// stable lock with timeout and bounded retries, and gates the system reset.
module pll_supervisor #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 7
) (
  input  logic              refclk,
  input  logic              reset_n,
  pll_supervisor_if.master  sup
);

  localparam int MAX_A = (RST_CYCLES > LOCK_STABLE)
                         ? ((RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT)
                         : ((LOCK_STABLE > LOCK_TIMEOUT) ? LOCK_STABLE : LOCK_TIMEOUT);
  localparam int CNT_W = (MAX_A > 2) ? $clog2(MAX_A) : 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       RTY_MAX  = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q, sync_d;
  logic [3:0]       retry_cnt_q, retry_cnt_d;
  logic [7:0]       lol_cnt_q, lol_cnt_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             locked_q, locked_d;
  logic             fault_q, fault_d;
  logic             lock_s;

  assign lock_s = sync_q[1];

  // Next-state, shared counter and registered-output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_cnt_d = retry_cnt_q;
    lol_cnt_d   = lol_cnt_q;
    sync_d      = {sync_q[0], sup.extlock};

    if (sup.force_relock) begin
      state_d     = RESET_PLL;
      retry_cnt_d = 4'd0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
          end else begin
            state_d = RESET_PLL;
          end
        end
        WAIT_LOCK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (lock_s) begin
            state_d = STABILIZE;
          end else if (cnt_q == TMO_LAST) begin
            if (retry_cnt_q == RTY_MAX) begin
              state_d = FAULT;
            end else begin
              retry_cnt_d = retry_cnt_q + 4'd1;
              state_d     = RESET_PLL;
            end
          end else begin
            state_d = WAIT_LOCK;
          end
        end
        STABILIZE: begin
          // A single dropped sample sends us back for a fresh timeout window, not a retry.
          if (!lock_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STB_LAST) begin
            state_d     = RUN;
            retry_cnt_d = 4'd0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d   = RESET_PLL;
            lol_cnt_d = (lol_cnt_q == 8'hFF) ? lol_cnt_q : lol_cnt_q + 8'd1;
          end else begin
            state_d = RUN;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = RESET_PLL;
      endcase
    end

    if (sup.force_relock || (state_d != state_q)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_d;
    end

    pll_reset_d = (state_d == RESET_PLL) || (state_d == FAULT);
    sys_rst_n_d = (state_d == RUN);
    locked_d    = (state_d == RUN);
    fault_d     = (state_d == FAULT);
  end

  // State, counter, synchronizer and output registers.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      sync_q      <= 2'b00;
      retry_cnt_q <= 4'd0;
      lol_cnt_q   <= 8'd0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      retry_cnt_q <= retry_cnt_d;
      lol_cnt_q   <= lol_cnt_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
    end
  end

  assign sup.pll_reset = pll_reset_q;
  assign sup.sys_rst_n = sys_rst_n_q;
  assign sup.locked    = locked_q;
  assign sup.fault     = fault_q;
  assign sup.retry_cnt = retry_cnt_q;
  assign sup.lol_cnt   = lol_cnt_q;

endmodule
